uart_rx: RTL
============

Name: uart_rx

Overview:
UART receiver, the far end of the existing 8N1 serial transmitter. It oversamples the asynchronous `rx` line with the system clock and recovers each 8-bit frame (LSB first). It presents the byte with a one-cycle `valid` strobe and flags malformed frames. It sits between the board RX pin and downstream byte consumers, such as the loopback checker or a FIFO.

Parameters:
- FREQ, 12000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- LIM, FREQ/BAUD, clocks per bit (1250 at defaults). Derived; must be ≥ 4.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- nrst  input  1  reset. Synchronous, active-high: asserted = 1, sampled on the rising edge of clk.
- rx  input  1  asynchronous serial line; idles high.
- data_out  output  8  last good received byte; holds until the next good frame.
- valid  output  1  one-cycle strobe: data_out was just updated.
- frame_err  output  1  one-cycle strobe: stop bit sampled low (or glitched start, see below).
- busy  output  1  high from start-edge detection until the frame ends.
- state  output  2  FSM state, for debug: 00 IDLE, 01 START, 11 DATA, 10 STOP.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: data_out=0, valid=0, frame_err=0, busy=0, state=IDLE.
  - Internal: sync flops = 1, bit counter = 0, baud counter = 0, shift register = 0.
- Reset mid-frame aborts the frame. No valid or frame_err is produced.
- Synchronizer: rx passes through a 2-flop synchronizer (rx_s). A falling edge is defined as rx_s_prev=1 and rx_s=0.
  - Input-to-decision latency: 2 clocks.
- Baud counter: 16-bit. Cleared on every state entry, and increments each clock otherwise.
- IDLE:
  - On a falling edge: go to START, counter=0, busy=1.
  - A line held low (break, or after a frame error) does not retrigger. A fresh 1→0 edge is required.
- START:
  - At counter==LIM/2-1 (mid start bit), sample rx_s.
  - If 1: glitch. Return to IDLE, busy=0, no strobes.
  - If 0: counter=0, bit index=0, go to DATA.
- DATA:
  - At counter==LIM-1 (mid-bit), shift rx_s into the shift register MSB and shift right. After 8 samples, bit 0 of the frame sits at data_out[0].
  - Counter clears and bit index increments.
  - After the 8th sample, go to STOP (or PARITY, see the optional feature).
- STOP:
  - At counter==LIM-1, sample rx_s and return to IDLE with busy=0. In the same cycle:
    - rx_s=1: data_out=shift register, valid=1 for exactly one clock.
    - rx_s=0: frame_err=1 for one clock; data_out unchanged.
- valid and frame_err are never high in the same cycle.
- Back-to-back frames: a start edge arriving in the half-bit after the stop sample is accepted. IDLE is re-entered at mid-stop, so no frame is lost.
- Frame timing: valid rises ≈ 9.5·LIM + 3 clocks after the start bit's falling edge on rx.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - One even-parity bit follows data bit 7. An extra state PARITY (encoding reuses 10; STOP becomes 3-bit encoding 100, and the state port widens to 3 bits) samples it at counter==LIM-1.
  - An added output parity_err (1 bit) strobes for one cycle alongside the stop decision when XOR(data bits, parity bit)=1.
  - valid is suppressed when parity_err=1. parity_err has reset value 0.
- When undefined:
  - 8N1 only. No parity_err port, state stays 2 bits.

Test Plan:
- Use FREQ=160, BAUD=10 (LIM=16). Hold nrst=1 for 3 clocks, rx=1 → all outputs 0 and state=00 during and after reset.
- Drive frame 0x53 (start 0, bits 1,1,0,0,1,0,1,0, stop 1) → data_out=0x53, one-cycle valid at ≈155 clocks after the falling edge; busy high throughout; frame_err=0.
- Two back-to-back frames 0x6E then 0x70 with no idle gap → two valid pulses with data_out=0x6E then 0x70; no frame_err.
- Frame 0xA5 with stop bit driven 0, then rx held low 40 clocks, then high → one frame_err pulse; data_out keeps its previous value; no new frame started while low.
- 3-clock low glitch on idle rx → busy pulses then returns to 0 by the half-bit check; no valid, no frame_err.
- Assert nrst during data bit 4 of frame 0xFF, then send 0x01 → no strobe for the aborted frame; data_out=0x01 with valid. With UART_RX_PARITY_EN: 0x01 with parity bit 0 → parity_err=1 and no valid.

Source files
------------

// File: rtl/uart_rx_if.sv
// Serial-receive bundle for uart_rx: the rx line in, the byte, strobes and debug state out.
// UART_RX_PARITY_EN adds parity_err and widens state to 3 bits.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    logic [2:0] state;
`else
    logic [1:0] state;
`endif

    modport master (
        input  rx,
        output data_out,
        output valid,
        output frame_err,
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        output busy,
        output state
    );

    modport slave (
        output rx,
        input  data_out,
        input  valid,
        input  frame_err,
`ifdef UART_RX_PARITY_EN
        input  parity_err,
`endif
        input  busy,
        input  state
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, oversampled by the system clock, LSB first, one-cycle valid/frame_err strobes.
// Define UART_RX_PARITY_EN for an even-parity bit after data bit 7 and a parity_err strobe.
module uart_rx #(
    parameter int unsigned FREQ = 12000000,
    parameter int unsigned BAUD = 9600,
    parameter int unsigned LIM  = FREQ / BAUD
) (
    input  logic     clk,
    input  logic     nrst,
    uart_rx_if.master bus
);

    localparam logic [15:0] LimM1  = 16'(LIM - 1);
    localparam logic [15:0] HalfM1 = 16'(LIM / 2 - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        StIdle   = 3'b000,
        StStart  = 3'b001,
        StData   = 3'b011,
        StParity = 3'b010,
        StStop   = 3'b100
    } state_e;
`else
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StStart = 2'b01,
        StData  = 2'b11,
        StStop  = 2'b10
    } state_e;
`endif

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        rx_meta_q, rx_s_q, rx_prev_q;
    logic        fall;
    logic        mid_bit;
`ifdef UART_RX_PARITY_EN
    logic        par_q, par_d;
    logic        perr_q, perr_d;
`endif

    // Sync flops reset high so a reset never manufactures a falling edge.
    always_ff @(posedge clk) begin
        if (nrst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign fall    = rx_prev_q & ~rx_s_q;
    assign mid_bit = (cnt_q == LimM1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (fall) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                // A start bit that is high again at its midpoint was only a glitch.
                if (cnt_q == HalfM1) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        bit_d   = '0;
                    end
                end
            end
            StData: begin
                if (mid_bit) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    cnt_d   = '0;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (mid_bit) begin
                    par_d   = rx_s_q;
                    cnt_d   = '0;
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                // Leave at mid-stop so a back-to-back start edge is still caught.
                if (mid_bit) begin
                    state_d = StIdle;
                    cnt_d   = '0;
`ifdef UART_RX_PARITY_EN
                    perr_d  = ^{shift_q, par_q};
                    if (rx_s_q && !perr_d) begin
`else
                    if (rx_s_q) begin
`endif
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end
                    ferr_d = ~rx_s_q;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.data_out  = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.state     = state_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`endif

endmodule
